int_req_ctrl: RTL and testbench

- Interrupt requester on the far side of the processor's `int_flag`/`ack` handshake; the processor's ICU is the responder.
- Collects up to NUM_IRQ external request lines, edge-detects them, applies a mask and fixed priority, and raises a single `int_flag`.
- Holds `int_flag` until `ack`, then tracks the in-service source until end-of-interrupt (`eoi`, pulsed when RTI retires).
- Enforces a hold-off gap so the processor's interrupt/RTI sequence cannot be re-entered early.

---
 rtl/int_req_ctrl.sv | 150 +++++++++++++++
 tb/tb_int_req_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/int_req_ctrl.sv
// Interrupt requester: edge-detects IRQ lines, masks and prioritises them, and runs the
// int_flag/ack/eoi handshake with a post-EOI hold-off. Optional ack timeout: INT_ACK_TIMEOUT_EN.
module int_req_ctrl #(
  parameter int NUM_IRQ        = 8,
  parameter int IDW            = 3,
  parameter int HOLDOFF_CYCLES = 4,
  parameter int ACK_TIMEOUT    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               ack,
  input  logic               eoi,
  output logic               int_flag,
  output logic [IDW-1:0]     irq_id,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending,
  output logic               timeout_err
);

  localparam int HCW = (HOLDOFF_CYCLES > 2) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_INIT = (HOLDOFF_CYCLES > 0) ? HCW'(HOLDOFF_CYCLES - 1) : '0;

  if (IDW != $clog2(NUM_IRQ) || ACK_TIMEOUT < 1) begin : g_bad_params
    $error("int_req_ctrl: IDW must equal clog2(NUM_IRQ) and ACK_TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE, S_HOLDOFF} state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_d_q, pending_q, pending_d;
  logic [IDW-1:0]     irq_id_q, irq_id_d;
  logic [HCW-1:0]     hcnt_q, hcnt_d;
  logic               int_flag_q, int_flag_d;
  logic               in_service_q, in_service_d;
  logic [NUM_IRQ-1:0] rise, elig, clr, id_onehot;
  logic [IDW-1:0]     sel_id;

`ifdef INT_ACK_TIMEOUT_EN
  localparam int TCW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic           timeout_err_q, timeout_err_d;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    rise      = irq & ~irq_d_q;
    elig      = pending_q & ~irq_mask;
    sel_id    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) sel_id = IDW'(i);
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      id_onehot[i] = (irq_id_q == IDW'(i));
    end
    clr      = '0;
    state_d  = state_q;
    irq_id_d = irq_id_q;
    hcnt_d   = hcnt_q;
`ifdef INT_ACK_TIMEOUT_EN
    tcnt_d        = tcnt_q;
    timeout_err_d = timeout_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (|elig) begin
          state_d  = S_REQ;
          irq_id_d = sel_id;
`ifdef INT_ACK_TIMEOUT_EN
          tcnt_d   = '0;
`endif
        end
      end
      S_REQ: begin
        // ack wins over both a coincident eoi and a coincident timeout
        if (ack) begin
          clr     = id_onehot;
          state_d = S_SERVICE;
        end
`ifdef INT_ACK_TIMEOUT_EN
        else if (tcnt_q == TCW'(ACK_TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = (HOLDOFF_CYCLES == 0) ? S_IDLE : S_HOLDOFF;
          hcnt_d        = HOLD_INIT;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
`endif
      end
      S_SERVICE: begin
        if (eoi) begin
          state_d = (HOLDOFF_CYCLES == 0) ? S_IDLE : S_HOLDOFF;
          hcnt_d  = HOLD_INIT;
        end
      end
      S_HOLDOFF: begin
        if (hcnt_q == '0) state_d = S_IDLE;
        else              hcnt_d  = hcnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // a rise coinciding with the ack clear keeps the bit set
    pending_d    = (pending_q & ~clr) | rise;
    int_flag_d   = (state_d == S_REQ);
    in_service_d = (state_d == S_SERVICE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
    if (!reset) begin
      state_q      <= S_IDLE;
      irq_d_q      <= '0;
      pending_q    <= '0;
      irq_id_q     <= '0;
      hcnt_q       <= '0;
      int_flag_q   <= 1'b0;
      in_service_q <= 1'b0;
`ifdef INT_ACK_TIMEOUT_EN
      tcnt_q        <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      irq_d_q      <= irq;
      pending_q    <= pending_d;
      irq_id_q     <= irq_id_d;
      hcnt_q       <= hcnt_d;
      int_flag_q   <= int_flag_d;
      in_service_q <= in_service_d;
`ifdef INT_ACK_TIMEOUT_EN
      tcnt_q        <= tcnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign int_flag   = int_flag_q;
  assign irq_id     = irq_id_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;
`ifdef INT_ACK_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_int_req_ctrl.sv
// Scoreboard bench for int_req_ctrl: directed stimulus queues cycle-stamped expected outputs,
// a monitor compares them 1 ns after each rising edge.
module tb_int_req_ctrl;

  logic       clk = 1'b0;
  logic       reset, ack, eoi;
  logic [7:0] irq, irq_mask;
  logic       int_flag, in_service, timeout_err;
  logic [2:0] irq_id;
  logic [7:0] pending;

  int_req_ctrl #(.NUM_IRQ(8), .IDW(3), .HOLDOFF_CYCLES(4), .ACK_TIMEOUT(32)) dut (
    .clk(clk), .reset(reset), .irq(irq), .irq_mask(irq_mask), .ack(ack), .eoi(eoi),
    .int_flag(int_flag), .irq_id(irq_id), .in_service(in_service), .pending(pending),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      name;
    logic [13:0] vec;   // {int_flag, irq_id, in_service, pending, timeout_err}
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic exp(input int n, input string nm, input logic f, input logic [2:0] id,
                     input logic s, input logic [7:0] p, input logic t);
    exp_t e;
    int   pos;
    e.cyc  = cyc + n;
    e.name = nm;
    e.vec  = {f, id, s, p, t};
    pos = q.size();
    while (pos > 0 && q[pos-1].cyc > e.cyc) pos--;
    q.insert(pos, e);
  endtask

  // monitor: pops every entry stamped for the current cycle
  always @(posedge clk) begin
    logic [13:0] act;
    #1;
    cyc++;
    act = {int_flag, irq_id, in_service, pending, timeout_err};
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      n_cmp++;
      if (q[0].cyc < cyc || act !== q[0].vec) begin
        n_fail++;
        $display("FAIL %s @cyc %0d: got flag/id/svc/pend/to=%b/%0d/%b/%h/%b want %b/%0d/%b/%h/%b",
                 q[0].name, cyc, act[13], act[12:10], act[9], act[8:1], act[0],
                 q[0].vec[13], q[0].vec[12:10], q[0].vec[9], q[0].vec[8:1], q[0].vec[0]);
      end
      void'(q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; irq = '0; irq_mask = '0; ack = 1'b0; eoi = 1'b0;
    tick(1);
    exp(1, "reset", 0, 0, 0, 8'h00, 0);
    tick(1);

    // single edge on irq[3]
    reset = 1'b1; irq = 8'h08;
    exp(1, "t1_pend", 0, 0, 0, 8'h08, 0);
    exp(2, "t1_req",  1, 3, 0, 8'h08, 0);
    tick(1); irq = '0;
    tick(1); ack = 1'b1;
    exp(1, "t1_ack", 0, 3, 1, 8'h00, 0);
    tick(1); ack = 1'b0; eoi = 1'b1;
    exp(1, "t1_eoi", 0, 3, 0, 8'h00, 0);
    tick(1); eoi = 1'b0;
    tick(6);

    // simultaneous edges on 5 and 2, priority then hold-off
    irq = 8'h24;
    exp(1, "t2_pend", 0, 3, 0, 8'h24, 0);
    exp(2, "t2_req2", 1, 2, 0, 8'h24, 0);
    tick(1); irq = '0;
    tick(1); ack = 1'b1;
    exp(1, "t2_ack2", 0, 2, 1, 8'h20, 0);
    tick(1); ack = 1'b0; eoi = 1'b1;
    exp(1, "t2_eoi",      0, 2, 0, 8'h20, 0);
    exp(5, "t2_holdoff",  0, 2, 0, 8'h20, 0);
    exp(6, "t2_req5",     1, 5, 0, 8'h20, 0);
    tick(1); eoi = 1'b0;
    tick(5); ack = 1'b1;
    exp(1, "t2_ack5", 0, 5, 1, 8'h00, 0);
    tick(1); ack = 1'b0; eoi = 1'b1;
    tick(1); eoi = 1'b0;
    tick(6);

    // masked source, then unmask
    irq_mask = 8'h02; irq = 8'h02;
    exp(1, "t3_pend",   0, 5, 0, 8'h02, 0);
    exp(2, "t3_masked", 0, 5, 0, 8'h02, 0);
    tick(1); irq = '0;
    tick(1); irq_mask = '0;
    exp(2, "t3_req1", 1, 1, 0, 8'h02, 0);
    tick(2); ack = 1'b1;
    exp(1, "t3_ack", 0, 1, 1, 8'h00, 0);
    tick(1); ack = 1'b0; eoi = 1'b1;
    tick(1); eoi = 1'b0;
    tick(6);

    // request is frozen against masking and higher-priority edges
    irq = 8'h10;
    exp(2, "t4_req4", 1, 4, 0, 8'h10, 0);
    tick(1); irq = '0;
    tick(1); irq = 8'h01; irq_mask = 8'h10;
    exp(1, "t4_frozen",  1, 4, 0, 8'h11, 0);
    exp(3, "t4_frozen2", 1, 4, 0, 8'h11, 0);
    tick(3); ack = 1'b1;
    exp(1, "t4_ack", 0, 4, 1, 8'h01, 0);
    tick(1); ack = 1'b0; eoi = 1'b1;
    exp(1, "t4_eoi",  0, 4, 0, 8'h01, 0);
    exp(6, "t4_req0", 1, 0, 0, 8'h01, 0);
    tick(1); eoi = 1'b0; irq = '0; irq_mask = '0;
    tick(5); ack = 1'b1;
    exp(1, "t4_ack0", 0, 0, 1, 8'h00, 0);
    tick(1); ack = 1'b0; eoi = 1'b1;
    tick(1); eoi = 1'b0;
    tick(6);

    // reset in REQ, reset in SERVICE, line held high through reset release
    irq = 8'h08;
    tick(1); irq = '0;
    tick(1); reset = 1'b0;
    exp(1, "t5_rst_req", 0, 0, 0, 8'h00, 0);
    tick(1); reset = 1'b1;
    tick(1); irq = 8'h08;
    tick(1); irq = '0;
    tick(1); ack = 1'b1;
    tick(1); ack = 1'b0; reset = 1'b0; irq = 8'h04;
    exp(1, "t5_rst_svc", 0, 0, 0, 8'h00, 0);
    tick(1); reset = 1'b1;
    exp(1, "t5_rel_edge", 0, 0, 0, 8'h04, 0);
    exp(2, "t5_rel_req",  1, 2, 0, 8'h04, 0);
    tick(2); ack = 1'b1;
    exp(1, "t5_ack", 0, 2, 1, 8'h00, 0);
    tick(1); ack = 1'b0; eoi = 1'b1;
    tick(1); eoi = 1'b0; irq = '0;
    tick(6);

    // stray ack/eoi in IDLE; ack+eoi together in REQ
    ack = 1'b1; eoi = 1'b1;
    exp(1, "t6_stray",  0, 2, 0, 8'h00, 0);
    exp(2, "t6_stray2", 0, 2, 0, 8'h00, 0);
    tick(2); ack = 1'b0; eoi = 1'b0; irq = 8'h08;
    tick(1); irq = '0;
    tick(1); ack = 1'b1; eoi = 1'b1;
    exp(1, "t6_ackeoi", 0, 3, 1, 8'h00, 0);
    tick(1); ack = 1'b0; eoi = 1'b0;
    exp(1, "t6_svc_hold", 0, 3, 1, 8'h00, 0);
    tick(1); eoi = 1'b1;
    tick(1); eoi = 1'b0;
    tick(6);

`ifdef INT_ACK_TIMEOUT_EN
    // no ack: timeout after 32 REQ cycles, then re-issue after hold-off
    irq = 8'h40;
    exp(33, "to_wait",    1, 6, 0, 8'h40, 0);
    exp(34, "to_err",     0, 6, 0, 8'h40, 1);
    exp(39, "to_reissue", 1, 6, 0, 8'h40, 1);
    tick(1); irq = '0;
    tick(40); ack = 1'b1;
    exp(1, "to_ack", 0, 6, 1, 8'h00, 1);
    tick(1); ack = 1'b0; eoi = 1'b1;
    tick(1); eoi = 1'b0;
    tick(6);
`endif

    for (int i = 0; i < 200 && q.size() > 0; i++) tick(1);
    if (q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
